// File: rtl/keypad_entry.sv
// keypad_entry
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
//   accumulates decimal digits into a 16-bit binary entry. '#' commits the
//   entry to value (one-cycle valid pulse), '*' clears the entry.
//
//   Optional feature: define KEYPAD_BACKSPACE_EN to make 'D' delete the last
//   typed digit. Undefined (default), 'D' is ignored like A/B/C.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   col      in   [3:0] keypad columns, active-low, asynchronous to CLK
//   row      out  [3:0] row drive, one-hot-low
//   entry    out  [15:0] value of the digits being typed
//   value    out  [15:0] last committed value
//   valid    out  one-cycle pulse when value updates
//   ndigits  out  [2:0] number of typed digits (0-5)
module keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] entry,
    output logic [15:0] value,
    output logic        valid,
    output logic [2:0]  ndigits
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_ACT      = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]    col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    r_q, r_d;
    logic [1:0]    c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   entry_q, entry_d;
    logic [15:0]   value_q, value_d;
    logic          valid_q, valid_d;
    logic [2:0]    ndigits_q, ndigits_d;

    // Key decode for the latched (row, col) position
    logic       is_digit;
    logic [3:0] dval;
    logic [19:0] ext;   // wide enough that entry*10+9 never wraps

    always_comb begin
        is_digit = 1'b1;
        dval     = 4'd0;
        case ({r_q, c_q})
            4'h0: dval = 4'd1;
            4'h1: dval = 4'd2;
            4'h2: dval = 4'd3;
            4'h4: dval = 4'd4;
            4'h5: dval = 4'd5;
            4'h6: dval = 4'd6;
            4'h8: dval = 4'd7;
            4'h9: dval = 4'd8;
            4'hA: dval = 4'd9;
            4'hD: dval = 4'd0;
            default: is_digit = 1'b0;
        endcase
        ext = 20'(entry_q) * 20'd10 + 20'(dval);
    end

    always_comb begin
        col_s1_d  = col;
        col_s2_d  = col_s1_q;
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        ndigits_d = ndigits_q;

        case (state_q)
            ST_SCAN: begin
                if (col_s2_q != 4'hF) begin
                    // Lowest-index low column wins
                    if (!col_s2_q[0])      c_d = 2'd0;
                    else if (!col_s2_q[1]) c_d = 2'd1;
                    else if (!col_s2_q[2]) c_d = 2'd2;
                    else                   c_d = 2'd3;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end else if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    r_d   = r_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (col_s2_q[c_q]) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ACT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACT: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
                if (is_digit) begin
                    if (ndigits_q < 3'd5 && ext <= 20'd65535) begin
                        entry_d   = ext[15:0];
                        ndigits_d = ndigits_q + 3'd1;
                    end
                end else if ({r_q, c_q} == 4'hE) begin          // '#'
                    value_d   = entry_q;
                    valid_d   = 1'b1;
                    entry_d   = '0;
                    ndigits_d = '0;
                end else if ({r_q, c_q} == 4'hC) begin          // '*'
                    entry_d   = '0;
                    ndigits_d = '0;
                end
`ifdef KEYPAD_BACKSPACE_EN
                else if ({r_q, c_q} == 4'hF && ndigits_q != 3'd0) begin  // 'D'
                    entry_d   = entry_q / 16'd10;
                    ndigits_d = ndigits_q - 3'd1;
                end
`else
`endif
            end
            default: begin // ST_RELEASE: row stays frozen until all keys up
                if (col_s2_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_s1_q  <= 4'hF;   // idle-high so reset release is not a press
            col_s2_q  <= 4'hF;
            state_q   <= ST_SCAN;
            r_q       <= 2'd0;
            c_q       <= 2'd0;
            cnt_q     <= '0;
            entry_q   <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            ndigits_q <= '0;
        end else begin
            col_s1_q  <= col_s1_d;
            col_s2_q  <= col_s2_d;
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            ndigits_q <= ndigits_d;
        end
    end

    assign row     = ~(4'b0001 << r_q);
    assign entry   = entry_q;
    assign value   = value_q;
    assign valid   = valid_q;
    assign ndigits = ndigits_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
//   Drives a behavioural 4x4 keypad into keypad_entry (SCAN_DIV=4,
//   DEBOUNCE=8). A reference model of the typing rules pushes expected
//   entry/ndigits changes and committed values into queues; a monitor pops
//   them whenever the DUT output changes or valid pulses.
module tb_keypad_entry;

    localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6, KB = 7;
    localparam int K7 = 8, K8 = 9, K9 = 10, KC = 11, KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] entry, value;
    logic        valid;
    logic [2:0]  ndigits;

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .col(col), .row(row),
        .entry(entry), .value(value), .valid(valid), .ndigits(ndigits)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: a held key shorts its row to its column
    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0, key_c = 2'd0;
    always_comb begin
        col = 4'hF;
        if (key_down && !row[key_r]) col[key_c] = 1'b0;
    end

    int checks = 0;
    int failures = 0;

    logic [18:0] exp_en[$];   // {entry, ndigits}
    logic [15:0] exp_val[$];

    int m_entry = 0, m_nd = 0, m_value = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: got %0d expected no event at %0t", name, act, $time);
    endtask

    function automatic int key_digit(input int k);
        case (k)
            K0: return 0;  K1: return 1;  K2: return 2;  K3: return 3;
            K4: return 4;  K5: return 5;  K6: return 6;  K7: return 7;
            K8: return 8;  K9: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic push_en();
        exp_en.push_back({16'(m_entry), 3'(m_nd)});
    endtask

    // Reference rules for one accepted key press
    task automatic model_apply(input int k);
        int d;
        d = key_digit(k);
        if (d >= 0) begin
            if (m_nd < 5 && m_entry * 10 + d <= 65535) begin
                m_entry = m_entry * 10 + d;
                m_nd++;
                push_en();
            end
        end else if (k == KHASH) begin
            m_value = m_entry;
            exp_val.push_back(16'(m_value));
            if (m_entry != 0 || m_nd != 0) begin
                m_entry = 0; m_nd = 0; push_en();
            end
        end else if (k == KSTAR) begin
            if (m_entry != 0 || m_nd != 0) begin
                m_entry = 0; m_nd = 0; push_en();
            end
        end else if (k == KD) begin
`ifdef KEYPAD_BACKSPACE_EN
            if (m_nd > 0) begin
                m_entry = m_entry / 10; m_nd--; push_en();
            end
`endif
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic press(input int k, input int hold, input int rel);
        model_apply(k);
        key_r = 2'(k / 4);
        key_c = 2'(k % 4);
        key_down = 1'b1;
        cycles(hold);
        key_down = 1'b0;
        cycles(rel);
        @(negedge CLK);
        check("entry_after_key", int'(entry), m_entry);
        check("ndigits_after_key", int'(ndigits), m_nd);
    endtask

    task automatic press_seq(input int ks[$]);
        foreach (ks[i]) press(ks[i], 40, 20);
    endtask

    // Scoreboard monitor
    logic [18:0] prev_en = '0;
    always @(negedge CLK) begin
        logic [18:0] cur, e;
        logic [15:0] v;
        if (RST_N === 1'b1 && valid === 1'b1) begin
            if (exp_val.size() == 0) fail_evt("valid_unexpected", int'(value));
            else begin
                v = exp_val.pop_front();
                check("committed_value", int'(value), int'(v));
            end
        end
        cur = {entry, ndigits};
        if (!$isunknown(cur) && cur != prev_en) begin
            if (exp_en.size() == 0) fail_evt("entry_change_unexpected", int'(cur));
            else begin
                e = exp_en.pop_front();
                check("entry_ndigits", int'(cur), int'(e));
            end
        end
        prev_en = cur;
    end

    initial begin
        int k;
        RST_N = 1'b0;
        cycles(3);
        @(negedge CLK);
        check("rst_row", int'(row), 4'hE);
        check("rst_entry", int'(entry), 0);
        check("rst_value", int'(value), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ndigits", int'(ndigits), 0);

        // Idle scan: row walks every 4 cycles
        RST_N = 1'b1;
        check("scan_row", int'(row), 4'hE);
        for (int i = 1; i < 20; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("scan_row", int'(row), int'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
        end

        press_seq('{K1, K2, K3, KHASH});
        check("value_123", int'(value), 123);

        // Overflow and digit-count limits
        press_seq('{K6, K5, K5, K3, K5, K6, K0, KHASH});
        check("value_65535", int'(value), 65535);
        press_seq('{K6, K5, K5, K3, K6});
        check("entry_6553", int'(entry), 6553);
        press(KSTAR, 40, 20);

        // Bouncy short contacts never reach the debounce threshold
        key_r = 2'd1; key_c = 2'd1;
        repeat (6) begin
            key_down = 1'b1; cycles(3);
            key_down = 1'b0; cycles(3);
        end
        cycles(20);
        @(negedge CLK);
        check("bounce_entry", int'(entry), 0);
        press(K5, 100, 20);

        press_seq('{K4, K2});
        press(KSTAR, 40, 20);
        check("star_keeps_value", int'(value), 65535);

        // Reset in the middle of holding '7'
        if (m_entry != 0 || m_nd != 0) begin
            m_entry = 0; m_nd = 0; push_en();
        end
        m_value = 0;
        key_r = 2'd2; key_c = 2'd0; key_down = 1'b1;
        cycles(8);
        RST_N = 1'b0;
        cycles(3);
        @(negedge CLK);
        check("midrst_row", int'(row), 4'hE);
        check("midrst_entry", int'(entry), 0);
        check("midrst_value", int'(value), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ndigits", int'(ndigits), 0);
        model_apply(K7);
        RST_N = 1'b1;
        cycles(45);
        key_down = 1'b0;
        cycles(20);
        @(negedge CLK);
        check("after_rst_entry", int'(entry), 7);
        check("after_rst_ndigits", int'(ndigits), 1);

        press_seq('{KSTAR, K9, K8, K7, KD});
`ifdef KEYPAD_BACKSPACE_EN
        check("backspace_entry", int'(entry), 98);
`else
        check("backspace_entry", int'(entry), 987);
`endif

        // Random typing
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 15));
            press(k, int'($urandom_range(40, 60)), int'($urandom_range(20, 30)));
        end
        press(KHASH, 40, 20);
        check("final_value", int'(value), m_value);

        cycles(10);
        check("pending_entry_events", exp_en.size(), 0);
        check("pending_value_events", exp_val.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
